// File: rtl/axis_read_addr.sv
// AXI read address stage: splits a word-length stream request into INCR
// bursts capped by BURST_MAX beats and by 4 KB address boundaries, and hands
// the word length to the downstream read data stage in the accept cycle.
module axis_read_addr #(
  parameter int unsigned CFG_DWIDTH     = 32,
  parameter int unsigned WIDTH_RATIO    = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_LEN_WIDTH  = 8,
  parameter int unsigned BURST_MAX      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_DWIDTH-1:0]     cfg_address,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_val,
  output logic                      cfg_rdy,
  output logic [CFG_DWIDTH-1:0]     len_length,
  output logic                      len_val,
  input  logic                      len_rdy,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
  output logic [2:0]                axi_arsize,
  output logic [1:0]                axi_arburst,
  output logic                      axi_arvalid,
  input  logic                      axi_arready
);

  localparam int unsigned BPB        = AXI_DATA_WIDTH / 8;
  localparam int unsigned BPB_LOG2   = $clog2(BPB);
  localparam int unsigned RATIO_LOG2 = $clog2(WIDTH_RATIO);
  // One extra bit so the round-up of a maximal length cannot overflow.
  localparam int unsigned REM_W      = CFG_DWIDTH + 1;
  // Wide enough to hold 4096, the largest possible beats-to-boundary count.
  localparam int unsigned BURST_W    = 13;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SETUP = 3'b010,
    S_ADDR  = 3'b100
  } state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REM_W-1:0]          rem_q, rem_d;
  logic [BURST_W-1:0]        burst_q, burst_d;

  logic                      len_nz;
  logic                      accept;
  logic [BURST_W-1:0]        boundary;
  logic [REM_W-1:0]          cap;
  logic [REM_W-1:0]          rem_after;

  // Request handshake and zero-latency length pass-through.
  assign len_nz     = |cfg_length;
  assign cfg_rdy    = ~rst & (state_q == S_IDLE) & (~len_nz | len_rdy);
  assign len_val    = ~rst & cfg_val & (state_q == S_IDLE) & len_nz;
  assign len_length = cfg_length;
  assign accept     = cfg_val & cfg_rdy & len_nz;

  // AXI AR channel driven straight from registered state.
  assign axi_arvalid = (state_q == S_ADDR);
  assign axi_araddr  = addr_q;
  assign axi_arlen   = AXI_LEN_WIDTH'(burst_q - BURST_W'(1));
  assign axi_arsize  = 3'(BPB_LOG2);
  assign axi_arburst = 2'b01;

  // Beats left before the next 4 KB boundary, and the tighter of that and BURST_MAX.
  assign boundary  = (BURST_W'(4096) - BURST_W'(addr_q[11:0])) >> BPB_LOG2;
  assign cap       = (REM_W'(BURST_MAX) < REM_W'(boundary)) ? REM_W'(BURST_MAX)
                                                            : REM_W'(boundary);
  assign rem_after = rem_q - REM_W'(burst_q);

  // Next-state logic: accept, size the burst, then present it until accepted.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    burst_d = burst_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = AXI_ADDR_WIDTH'(cfg_address) & ~AXI_ADDR_WIDTH'(BPB - 1);
          rem_d   = (REM_W'(cfg_length) + REM_W'(WIDTH_RATIO - 1)) >> RATIO_LOG2;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        burst_d = (rem_q < cap) ? BURST_W'(rem_q) : BURST_W'(cap);
        state_d = S_ADDR;
      end
      S_ADDR: begin
        if (axi_arready) begin
          addr_d  = addr_q + (AXI_ADDR_WIDTH'(burst_q) << BPB_LOG2);
          rem_d   = rem_after;
          state_d = (rem_after != '0) ? S_SETUP : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: tb/tb_axis_read_addr.sv
// Bench for axis_read_addr: directed cases plus randomized streams compared
// against a burst-list model computed directly from the splitting rules.
module tb_axis_read_addr;

  logic        clk;
  logic        rst;
  logic [31:0] cfg_address;
  logic [31:0] cfg_length;
  logic        cfg_val;
  logic        cfg_rdy;
  logic [31:0] len_length;
  logic        len_val;
  logic        len_rdy;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;

  int n_assert;
  int n_fail;

  axis_read_addr #(
    .CFG_DWIDTH(32), .WIDTH_RATIO(2), .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(64), .AXI_LEN_WIDTH(8), .BURST_MAX(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_address(cfg_address), .cfg_length(cfg_length),
    .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
    .len_length(len_length), .len_val(len_val), .len_rdy(len_rdy),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request starting at a negedge and checks the whole burst list.
  // rdy_pct: chance of arready per cycle; max_wait: cycles before arready is forced.
  task automatic run_stream(input logic [31:0] a, input logic [31:0] l,
                            input int rdy_pct, input int max_wait);
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_len[$];
    logic [31:0] ad;
    longint      beats;
    longint      bnd;
    longint      b;
    int          waits;
    bit          hs;

    // Reference: round words up to beats, then peel off bursts.
    ad    = a & ~32'h7;
    beats = (longint'(l) + 1) / 2;
    while (beats > 0) begin
      bnd = (4096 - longint'(ad % 4096)) / 8;
      b   = beats;
      if (b > 16)  b = 16;
      if (b > bnd) b = bnd;
      exp_addr.push_back(ad);
      exp_len.push_back(8'(b - 1));
      ad    = ad + 32'(b * 8);
      beats = beats - b;
    end

    cfg_address = a;
    cfg_length  = l;
    cfg_val     = 1'b1;
    len_rdy     = 1'b1;
    #1;
    check("cfg_rdy_accept", cfg_rdy, 1);
    check("len_val_accept", len_val, (l != 0) ? 1 : 0);
    if (l != 0) check("len_length", len_length, l);
    @(negedge clk);
    cfg_val = 1'b0;
    check("setup_gap_arvalid", axi_arvalid, 0);
    if (l == 0) begin
      check("zero_len_idle_rdy", cfg_rdy, 1);
      return;
    end
    check("busy_cfg_rdy", cfg_rdy, 0);

    for (int i = 0; i < exp_addr.size(); i++) begin
      @(negedge clk);
      check("arvalid", axi_arvalid, 1);
      check("araddr", axi_araddr, exp_addr[i]);
      check("arlen", axi_arlen, exp_len[i]);
      check("arsize", axi_arsize, 3);
      check("arburst", axi_arburst, 1);
      waits = 0;
      forever begin
        hs = (waits >= max_wait) || ($urandom_range(99) < rdy_pct);
        axi_arready = hs;
        @(negedge clk);
        axi_arready = 1'b0;
        if (hs) break;
        waits++;
        check("hold_arvalid", axi_arvalid, 1);
        check("hold_araddr", axi_araddr, exp_addr[i]);
        check("hold_arlen", axi_arlen, exp_len[i]);
      end
      check("post_hs_arvalid", axi_arvalid, 0);
      check("post_hs_cfg_rdy", cfg_rdy, (i == exp_addr.size() - 1) ? 1 : 0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rl;
    logic [11:0] off;

    n_assert    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    cfg_address = '0;
    cfg_length  = '0;
    cfg_val     = 1'b0;
    len_rdy     = 1'b1;
    axi_arready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_arvalid", axi_arvalid, 0);
    check("rst_cfg_rdy", cfg_rdy, 0);
    rst = 1'b0;
    #1;
    check("idle_cfg_rdy", cfg_rdy, 1);
    check("idle_len_val", len_val, 0);
    @(negedge clk);

    // Directed cases from the plan.
    run_stream(32'h0000_1000, 32'd64, 100, 0);
    run_stream(32'h0000_2004, 32'd5, 100, 0);
    run_stream(32'h0000_0FF0, 32'd16, 100, 0);
    run_stream(32'h0000_0FF0, 32'd16, 0, 10);
    run_stream(32'h0000_4000, 32'd64, 0, 10);
    run_stream(32'hFFFF_FFF0, 32'd8, 100, 0);
    run_stream(32'h0000_7000, 32'd1, 100, 0);

    // Zero-length request consumed even with len_rdy low.
    cfg_address = 32'h0000_6000;
    cfg_length  = 32'd0;
    cfg_val     = 1'b1;
    len_rdy     = 1'b0;
    #1;
    check("zero_cfg_rdy", cfg_rdy, 1);
    check("zero_len_val", len_val, 0);
    @(negedge clk);
    cfg_length = 32'd8;
    #1;
    check("zero_no_arvalid", axi_arvalid, 0);
    check("stall_cfg_rdy", cfg_rdy, 0);
    check("stall_len_val", len_val, 1);
    repeat (3) begin
      @(negedge clk);
      check("stall_no_arvalid", axi_arvalid, 0);
      check("stall_cfg_rdy_hold", cfg_rdy, 0);
    end
    run_stream(32'h0000_6000, 32'd8, 100, 0);

    // Reset while an address is being presented.
    cfg_address = 32'h0000_3000;
    cfg_length  = 32'd64;
    cfg_val     = 1'b1;
    len_rdy     = 1'b1;
    @(negedge clk);
    cfg_val = 1'b0;
    @(negedge clk);
    check("pre_rst_arvalid", axi_arvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_arvalid", axi_arvalid, 0);
    check("mid_rst_cfg_rdy", cfg_rdy, 0);
    rst = 1'b0;
    #1;
    check("post_rst_cfg_rdy", cfg_rdy, 1);
    @(negedge clk);
    check("post_rst_arvalid", axi_arvalid, 0);
    run_stream(32'h0000_5008, 32'd20, 100, 0);

    // Randomized streams, half of them parked just below a 4 KB boundary.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      if (i % 2 == 1) begin
        off = 12'hFFF - 12'($urandom_range(0, 300));
        ra[11:0] = off;
      end
      rl = 32'($urandom_range(1, 300));
      if (i % 10 == 0) rl = 32'd0;
      run_stream(ra, rl, $urandom_range(20, 100), 15);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_read_addr.md
Name: axis_read_addr

Overview:
AXI read address channel stage for the read path: the upstream neighbour of the read data stage. Accepts a stream request (byte start address, length in DATA_WIDTH words) and splits it into AXI INCR bursts. Bursts are limited by BURST_MAX beats and never cross a 4 KB boundary. Forwards the word length to the read data stage's config port, so both stages process the same stream.

Parameters:
CFG_DWIDTH, 32, width of cfg address/length words
WIDTH_RATIO, 2, DATA_WIDTH words per AXI beat (power of 2)
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 64, AXI data width; bytes per beat BPB = AXI_DATA_WIDTH/8
AXI_LEN_WIDTH, 8, arlen width
BURST_MAX, 16, max beats per burst (1..2^AXI_LEN_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_address  in  CFG_DWIDTH  stream start byte address; low log2(BPB) bits ignored (treated as 0)
cfg_length  in  CFG_DWIDTH  stream length in DATA_WIDTH words
cfg_val  in  1  request valid
cfg_rdy  out  1  request accepted when cfg_val&cfg_rdy
len_length  out  CFG_DWIDTH  length forwarded to read data stage
len_val  out  1  forwarded length valid
len_rdy  in  1  read data stage can accept length
axi_araddr  out  AXI_ADDR_WIDTH  burst address
axi_arlen  out  AXI_LEN_WIDTH  beats-1
axi_arsize  out  3  constant log2(BPB)
axi_arburst  out  2  constant 2'b01 (INCR)
axi_arvalid  out  1  address valid
axi_arready  in  1  slave accepts address

Behaviour:
- States, one-hot: IDLE, SETUP, ADDR. Reset -> IDLE, axi_arvalid=0, internal counters 0.
- IDLE: cfg_rdy = (cfg_length==0) | len_rdy. It is 0 in SETUP/ADDR and during rst.
- len_val = cfg_val & IDLE & (cfg_length!=0); len_length = cfg_length. Pass-through is combinational and has zero latency, so the length transfer happens in the same cycle as cfg acceptance.
- Zero-length request: accepted and dropped. No len_val, no bursts, state stays IDLE.
- Accept (nonzero): latch addr = cfg_address with low bits cleared. Latch remaining beats = ceil(cfg_length/WIDTH_RATIO), computed at CFG_DWIDTH+1 bits so cfg_length=2^32-1 does not overflow. Go to SETUP.
- SETUP (1 cycle): boundary = (4096 - addr[11:0]) / BPB. Register burst = min(remaining, BURST_MAX, boundary). Then go to ADDR.
- ADDR: axi_arvalid=1, axi_araddr=addr, axi_arlen=burst-1. These outputs are held stable until axi_arready. On handshake: addr += burst*BPB (mod 2^AXI_ADDR_WIDTH), remaining -= burst, arvalid deasserts next cycle. Next state is SETUP if remaining after the subtract is >0, else IDLE.
- Latency: accept at cycle N -> arvalid first high at N+2. Between bursts, arvalid is low for exactly one cycle (SETUP).
- The next request is accepted only in IDLE; there is no overlap between streams.
- arready high while in IDLE/SETUP has no effect.
- Reset mid-burst: arvalid=0 the cycle after rst is sampled, and the request is discarded.
- No limit on outstanding bursts. Back-pressure comes from the slave via arready.

Test Plan:
AXI_DATA_WIDTH=64 (BPB=8), WIDTH_RATIO=2, BURST_MAX=16 unless stated.
- addr=0x1000, length=64, arready=1: len_val pulse with 64 in the accept cycle. Bursts (0x1000, arlen 15) then (0x1080, arlen 15). Back to IDLE; cfg_rdy high again the cycle after the second handshake.
- addr=0x2004, length=5: single burst araddr=0x2000, arlen=2 (3 beats).
- addr=0x0FF0, length=16 (8 beats): 4 KB split gives (0x0FF0, arlen 1) then (0x1000, arlen 5).
- arready held low 10 cycles in ADDR: arvalid, araddr and arlen stay constant. On the arready pulse they advance to the next burst after the SETUP cycle.
- length=0 with len_rdy=0: cfg_rdy=1, request consumed, no len_val, no arvalid. Then length=8 with len_rdy=0: cfg_rdy=0 and nothing issues until len_rdy=1.
- rst asserted while arvalid=1 mid-stream: next cycle arvalid=0 and state IDLE. A new request then restarts correctly from its own address.
